// File: rtl/sram_axi_slave.sv
// sram_axi_slave: AXI4 slave (one transaction in flight, INCR bursts up to 16 beats) driving a synchronous single-port SRAM.
// Ports: clk/rst (async active-low), AXI AW/W/B/AR/R channels, SRAM side CS/OE/WEB/A/DI/DO.
module sram_axi_slave #(
  parameter int IDW     = 8,
  parameter int AW_SRAM = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDW-1:0]     AWID,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [IDW-1:0]     BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [IDW-1:0]     ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [IDW-1:0]     RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               CS,
  output logic               OE,
  output logic [3:0]         WEB,
  output logic [AW_SRAM-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);
  typedef enum logic [2:0] {IDLE, R_ACC, R_DATA, W_DATA, W_RESP} state_t;
  state_t state, state_nx;
  logic [31:0] addr;
  logic [3:0] len, cnt;
  logic [IDW-1:0] id;
  logic aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic unused;
  assign unused = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, addr[31:AW_SRAM+2], addr[1:0]};
  assign aw_hs = AWVALID & AWREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign w_hs  = WVALID & WREADY;
  assign r_hs  = RVALID & RREADY;
  assign b_hs  = BVALID & BREADY;
  always_comb begin
    AWREADY = (state == IDLE) & rst;
    ARREADY = AWREADY & ~AWVALID;
    WREADY  = state == W_DATA;
    BVALID  = state == W_RESP;
    RVALID  = state == R_DATA;
    RLAST   = RVALID & (cnt == len);
    RDATA   = DO;
    RID     = id;
    BID     = id;
    RRESP   = 2'b00;
    BRESP   = 2'b00;
    OE      = (state == R_ACC) | (state == R_DATA);
    CS      = OE | w_hs;
    WEB     = w_hs ? ~WSTRB : 4'hF;
    A       = addr[AW_SRAM+1:2];
    DI      = w_hs ? WDATA : '0;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = aw_hs ? W_DATA : ar_hs ? R_ACC : IDLE;
      R_ACC:   state_nx = R_DATA;
      R_DATA:  state_nx = r_hs ? (RLAST ? IDLE : R_ACC) : R_DATA;
      W_DATA:  state_nx = (w_hs & WLAST) ? W_RESP : W_DATA;
      W_RESP:  state_nx = b_hs ? IDLE : W_RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      id    <= '0;
    end else begin
      state <= state_nx;
      if (aw_hs) begin
        id   <= AWID;
        addr <= AWADDR;
        len  <= AWLEN;
      end else if (ar_hs) begin
        id   <= ARID;
        addr <= ARADDR;
        len  <= ARLEN;
        cnt  <= '0;
      end
      if (w_hs || (r_hs && !RLAST)) addr <= addr + 32'd4;
      if (r_hs && !RLAST) cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave: randomized self-checking bench with a word-array reference model of SRAM contents.
module tb_sram_axi_slave;
  localparam int IDW = 8;
  localparam int AWS = 14;
  localparam int DEPTH = 1 << AWS;
  logic clk = 0, rst = 0;
  logic [IDW-1:0] AWID = 0, ARID = 0, BID, RID;
  logic [31:0] AWADDR = 0, ARADDR = 0, WDATA = 0, RDATA, DI, DO;
  logic [3:0] AWLEN = 0, ARLEN = 0, WSTRB = 0, WEB;
  logic [2:0] AWSIZE = 3'b010, ARSIZE = 3'b010;
  logic [1:0] AWBURST = 2'b01, ARBURST = 2'b01, BRESP, RRESP;
  logic AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
  logic ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0, CS, OE;
  logic [AWS-1:0] A;
  int n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] sram [DEPTH];
  logic [31:0] do_q = 0;
  bit init_done = 0;
  assign DO = do_q;

  sram_axi_slave #(.IDW(IDW), .AW_SRAM(AWS)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
      init_done <= 1;
    end else if (CS) begin
      if (OE) do_q <= sram[A];
      for (int i = 0; i < 4; i++) if (!WEB[i]) sram[A][8*i +: 8] <= DI[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] widx(input logic [31:0] addr, input int b);
    return ((addr >> 2) + 32'(b)) & 32'(DEPTH - 1);
  endfunction

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [31:0] d0, input logic [3:0] s0, input bit gaps, input int bdly);
    int n;
    logic [31:0] d, idx;
    logic [3:0] s, ws;
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWVALID = 1;
    @(negedge clk);
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 32'(n), 0);
    if (ARVALID) chk("ar_blocked_by_aw", 32'(ARREADY), 0);
    @(posedge clk); #1 AWVALID = 0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        WVALID = 0;
        @(negedge clk);
        chk("gap_web", 32'(WEB), 32'hF);
        chk("gap_cs", 32'(CS), 0);
        @(posedge clk); #1;
      end
      d = (b == 0) ? d0 : $urandom;
      s = (b == 0) ? s0 : 4'($urandom);
      ws = ~s;
      idx = widx(addr, b);
      WDATA = d; WSTRB = s; WLAST = (b == len); WVALID = 1;
      @(negedge clk);
      chk("wready", 32'(WREADY), 1);
      chk("w_web", 32'(WEB), 32'(ws));
      chk("w_addr", 32'(A), idx);
      chk("w_di", DI, d);
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      @(posedge clk); #1;
    end
    WVALID = 0; WLAST = 0;
    @(negedge clk);
    n = 0;
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_timeout", 32'(n), 0);
    chk("bid", 32'(BID), 32'(id));
    chk("bresp", 32'(BRESP), 0);
    repeat (bdly) begin
      @(negedge clk);
      chk("b_hold", 32'(BVALID), 1);
      if (ARVALID) chk("ar_wait_b", 32'(ARREADY), 0);
    end
    BREADY = 1;
    @(posedge clk); #1 BREADY = 0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input bit rnd, input int sb, input int sc);
    int n, k;
    logic [31:0] exp;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARVALID = 1;
    @(negedge clk);
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 32'(n), 0);
    @(posedge clk); #1 ARVALID = 0;
    for (int b = 0; b <= len; b++) begin
      @(negedge clk);
      n = 0;
      while (!RVALID && n < 20) begin @(negedge clk); n++; end
      chk(b == 0 ? "r_first_latency" : "r_beat_spacing", 32'(n), b == 0 ? 1 : 1);
      exp = ref_mem[widx(addr, b)];
      chk("rdata", RDATA, exp);
      chk("rid", 32'(RID), 32'(id));
      chk("rlast", 32'(RLAST), 32'(b == len));
      chk("rresp", 32'(RRESP), 0);
      chk("r_addr", 32'(A), widx(addr, b));
      k = rnd ? $urandom_range(0, 2) : (b == sb ? sc : 0);
      repeat (k) begin
        @(negedge clk);
        chk("r_stall_valid", 32'(RVALID), 1);
        chk("r_stall_data", RDATA, exp);
      end
      RREADY = 1;
      @(posedge clk); #1 RREADY = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clk);
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_cs", 32'(CS), 0);
    chk("rst_web", 32'(WEB), 32'hF);
    chk("rst_a", 32'(A), 0);
    chk("rst_di", DI, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_awready", 32'(AWREADY), 1);
    chk("idle_arready", 32'(ARREADY), 1);
    @(posedge clk); #1;
    do_read(8'h12, 32'h10, 0, 0, 0, 0);
    do_write(8'h34, 32'h8, 0, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_read(8'h01, 32'h8, 0, 0, 0, 0);
    do_read(8'h56, 32'h100, 3, 0, 1, 3);
    ARID = 8'h77; ARADDR = 32'h20; ARLEN = 4'd1; ARVALID = 1;
    do_write(8'h66, 32'h40, 1, 32'h11223344, 4'hF, 0, 2);
    do_read(8'h77, 32'h20, 1, 0, 0, 0);
    do_write(8'h21, 32'h200, 2, 32'hCAFEF00D, 4'hF, 1, 5);
    do_read(8'h22, 32'h200, 2, 0, 0, 0);
    do_read(8'h23, 32'hFFF0_FFF8, 3, 0, 0, 0);
    ARID = 8'h99; ARADDR = 32'h30; ARLEN = 4'd3; ARVALID = 1;
    @(posedge clk); #1 ARVALID = 0;
    repeat (2) @(negedge clk);
    RREADY = 1;
    @(posedge clk); #1 RREADY = 0;
    repeat (2) @(negedge clk);
    chk("mid_beat2_valid", 32'(RVALID), 1);
    rst = 0;
    #1;
    chk("mid_rst_rvalid", 32'(RVALID), 0);
    chk("mid_rst_cs", 32'(CS), 0);
    chk("mid_rst_web", 32'(WEB), 32'hF);
    chk("mid_rst_rlast", 32'(RLAST), 0);
    @(negedge clk);
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(RVALID), 0);
      chk("post_rst_bvalid", 32'(BVALID), 0);
    end
    @(posedge clk); #1;
    do_read(8'h9A, 32'h30, 3, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ad;
      ad = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0, 16'($urandom_range(0, 63) << 2)};
      if ($urandom_range(0, 1))
        do_write(8'($urandom), ad, $urandom_range(0, 15), $urandom, 4'($urandom), 1, $urandom_range(0, 3));
      else
        do_read(8'($urandom), ad, $urandom_range(0, 15), 1, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
